div_32_seq: RTL and testbench

DIV_32_SEQ -- requirements
Module: div_32_seq

---
 rtl/div_32_seq.sv | 184 ++++++++++++++++++
 tb/tb_div_32_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/div_32_seq.sv
// div_32_seq: 32-bit signed sequential divider using restoring division.
// Operands are converted to magnitudes when start is accepted. One quotient
// bit is produced per cycle over 32 RUN cycles. Signs are applied on entry to
// DONE, and the results are registered there. done pulses on the cycle after
// DONE. A zero divisor skips RUN and goes straight to DONE with V set.
module div_32_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] S,
  input  logic [31:0] T,
  output logic        busy,
  output logic        done,
  output logic [31:0] Y_hi,
  output logic [31:0] Y_lo,
  output logic        N,
  output logic        Z,
  output logic        V,
  output logic        C
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Magnitude of a two's complement word; 32'h80000000 yields unsigned 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    abs32 = x[31] ? (~x + 32'd1) : x;
  endfunction

  // Two's complement negation.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    neg32 = ~x + 32'd1;
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        sgn_rem_q, sgn_rem_d;
  logic        sgn_quo_q, sgn_quo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] y_hi_q, y_hi_d;
  logic [31:0] y_lo_q, y_lo_d;
  logic        n_q, n_d;
  logic        z_q, z_d;
  logic        v_q, v_d;

  logic [32:0] shift_s;
  logic [32:0] diff_s;
  logic [31:0] step_rem_s;
  logic [31:0] step_quo_s;
  logic [31:0] fin_quo_s;
  logic [31:0] fin_rem_s;

  // One restoring step: shift in the next dividend bit, then try to subtract the divisor.
  always_comb begin
    shift_s    = {rem_q, quo_q[31]};
    diff_s     = shift_s - {1'b0, dvs_q};
    step_rem_s = 32'd0;
    if (diff_s[32]) begin
      step_rem_s = shift_s[31:0];
    end else begin
      step_rem_s = diff_s[31:0];
    end
    step_quo_s = {quo_q[30:0], ~diff_s[32]};
    fin_quo_s  = sgn_quo_q ? neg32(step_quo_s) : step_quo_s;
    fin_rem_s  = sgn_rem_q ? neg32(step_rem_s) : step_rem_s;
  end

  // Next-state and datapath decode for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    sgn_rem_d = sgn_rem_q;
    sgn_quo_d = sgn_quo_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    y_hi_d    = y_hi_q;
    y_lo_d    = y_lo_q;
    n_d       = n_q;
    z_d       = z_q;
    v_d       = v_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d     = 32'd0;
          quo_d     = abs32(S);
          dvs_d     = abs32(T);
          sgn_rem_d = S[31];
          sgn_quo_d = S[31] ^ T[31];
          cnt_d     = 6'd0;
          if (T == 32'd0) begin
            state_d = DONE;
            y_lo_d  = 32'hFFFF_FFFF;
            y_hi_d  = S;
            n_d     = 1'b1;
            z_d     = 1'b0;
            v_d     = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rem_d = step_rem_s;
        quo_d = step_quo_s;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = DONE;
          y_lo_d  = fin_quo_s;
          y_hi_d  = fin_rem_s;
          n_d     = fin_quo_s[31];
          z_d     = (fin_quo_s == 32'd0);
          v_d     = 1'b0;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation and restores the idle values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      sgn_rem_q <= 1'b0;
      sgn_quo_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      y_hi_q    <= 32'd0;
      y_lo_q    <= 32'd0;
      n_q       <= 1'b0;
      z_q       <= 1'b1;
      v_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      sgn_rem_q <= sgn_rem_d;
      sgn_quo_q <= sgn_quo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      y_hi_q    <= y_hi_d;
      y_lo_q    <= y_lo_d;
      n_q       <= n_d;
      z_q       <= z_d;
      v_q       <= v_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Y_hi = y_hi_q;
  assign Y_lo = y_lo_q;
  assign N    = n_q;
  assign Z    = z_q;
  assign V    = v_q;
  assign C    = 1'b0;

endmodule

// File: tb/tb_div_32_seq.sv
// tb_div_32_seq: directed, table-driven bench for div_32_seq with
// hand-computed quotient, remainder and flag values.
module tb_div_32_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] S;
  logic [31:0] T;
  logic        busy;
  logic        done;
  logic [31:0] Y_hi;
  logic [31:0] Y_lo;
  logic        N;
  logic        Z;
  logic        V;
  logic        C;

  int tests;
  int failed;

  typedef struct {
    logic [31:0] s;
    logic [31:0] t;
    logic [31:0] q;
    logic [31:0] r;
    logic        n;
    logic        z;
    logic        v;
  } vec_t;

  vec_t vecs[14];

  div_32_seq dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .S    (S),
    .T    (T),
    .busy (busy),
    .done (done),
    .Y_hi (Y_hi),
    .Y_lo (Y_lo),
    .N    (N),
    .Z    (Z),
    .V    (V),
    .C    (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and check latency, busy, results, flags and hold behaviour.
  task automatic run_op(input vec_t v);
    int lat;
    int busy_cnt;
    logic early;
    lat      = (v.t == 32'd0) ? 1 : 33;
    busy_cnt = 0;
    early    = 1'b0;
    @(negedge clk);
    S     = v.s;
    T     = v.t;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    S     = $urandom;
    T     = $urandom;
    check("busy_after_start", {31'd0, busy}, {31'd0, (v.t != 32'd0)});
    for (int i = 1; i < lat; i++) begin
      @(posedge clk);
      #1;
      if (done) early = 1'b1;
      if (busy) busy_cnt++;
    end
    check("no_early_done", {31'd0, early}, 32'd0);
    check("busy_cycles", busy_cnt, (v.t != 32'd0) ? 31 : 0);
    @(posedge clk);
    #1;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("Y_lo", Y_lo, v.q);
    check("Y_hi", Y_hi, v.r);
    check("N", {31'd0, N}, {31'd0, v.n});
    check("Z", {31'd0, Z}, {31'd0, v.z});
    check("V", {31'd0, V}, {31'd0, v.v});
    check("C", {31'd0, C}, 32'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("Y_lo_hold", Y_lo, v.q);
    check("Y_hi_hold", Y_hi, v.r);
  endtask

  initial begin
    logic seen;
    vec_t nine_three;
    tests  = 0;
    failed = 0;

    vecs[0]  = '{32'd100,       32'd7,         32'h0000_000E, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{32'd5,         32'd0,         32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'd0,         32'd5,         32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{32'd7,         32'd100,       32'h0000_0000, 32'h0000_0007, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{32'h8000_0000, 32'd2,         32'hC000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{32'hFFFF_FFFF, 32'd2,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
    nine_three = '{32'd9, 32'd3, 32'h0000_0003, 32'h0000_0000, 1'b0, 1'b0, 1'b0};

    reset = 1'b0;
    start = 1'b0;
    S     = 32'd0;
    T     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_Y_hi", Y_hi, 32'd0);
    check("rst_Y_lo", Y_lo, 32'd0);
    check("rst_flags", {28'd0, N, Z, V, C}, 32'h0000_0004);
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 14; k++) begin
      run_op(vecs[k]);
    end

    // A second start at edge 10 while busy must be ignored and not queued.
    @(negedge clk);
    S = 32'd100; T = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    S = 32'd1; T = 32'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    check("ign_no_done_e32", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    check("ign_done_e33", {31'd0, done}, 32'd1);
    check("ign_Y_lo", Y_lo, 32'd14);
    check("ign_Y_hi", Y_hi, 32'd2);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("ign_not_queued", {31'd0, seen}, 32'd0);

    // Reset mid-RUN aborts with no done and restores reset values.
    @(negedge clk);
    S = 32'd100; T = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_Y_hi", Y_hi, 32'd0);
    check("mid_rst_Y_lo", Y_lo, 32'd0);
    check("mid_rst_flags", {28'd0, N, Z, V, C}, 32'h0000_0004);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check("mid_rst_no_done", {31'd0, seen}, 32'd0);
    run_op(nine_three);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
